gtp_usrclk_seq: RTL and testbench

- Free-running sequencer for the GTP-fed MMCM that derives the 125 MHz GMII clock and its 90° companion.
- Holds the MMCM in reset until the GTP reports its recovered clock valid, then releases it and waits for lock with a timeout and retry.
- Requires lock to stay stable before releasing the downstream GMII-domain reset.
- Recovers on lock loss, GTP drop or a software request. Runs on an independent system clock, so every status input is asynchronous.

---
 rtl/gtp_usrclk_seq.sv | 193 +++++++++++++++++++
 tb/tb_gtp_usrclk_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gtp_usrclk_seq.sv
// gtp_usrclk_seq: reset/lock sequencer for the GTP-fed MMCM that makes the
// 125 MHz GMII clock and its 90-degree companion.
//
// The MMCM is held in reset until the GTP recovered clock is valid. The
// sequencer then waits for LOCKED, with a timeout and retry. Lock must stay
// stable for STABLE_CYCLES before the GMII-domain reset is released. Lock
// loss, a GTP drop or a software pulse restarts the whole sequence.
//
// Optional build macro GTP_USRCLK_SEQ_COUNTERS_EN:
//   defined   -> retry_cnt / loss_cnt are saturating 8-bit event counters
//   undefined -> both outputs are tied to 8'd0 (state machine unchanged)
//
// gtp_clk_valid and pll_lock come from other clock domains. Each one passes
// through a 2-flop synchroniser before any decision uses it.

module gtp_usrclk_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gtp_clk_valid,
  input  logic       pll_lock,
  input  logic       soft_rst,
  output logic       mmcm_rst,
  output logic       usr_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_WAIT   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  // Terminal counts of the shared phase counter, one for each timed phase
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]       v_sync_q, l_sync_q;
  logic             v_s, l_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mmcm_rst_q, usr_rst_q, ready_q;
`ifdef GTP_USRCLK_SEQ_COUNTERS_EN
  logic             retry_inc, loss_inc;
  logic [7:0]       retry_q, loss_q;
`endif

  // 2-flop synchronisers for the asynchronous status inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sync_q <= 2'b00;
      l_sync_q <= 2'b00;
    end else begin
      v_sync_q <= {v_sync_q[0], gtp_clk_valid};
      l_sync_q <= {l_sync_q[0], pll_lock};
    end
  end

  assign v_s = v_sync_q[1];
  assign l_s = l_sync_q[1];

  // State register, phase counter and registered output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      mmcm_rst_q <= 1'b1;
      usr_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // Each output is decoded from the next state into its own flop.
      // Every output therefore changes on the same edge as state_q, and it
      // carries no decode glitch. mmcm_rst and usr_rst rise together on
      // entry to HOLD.
      mmcm_rst_q <= (state_d == S_HOLD);
      usr_rst_q  <= (state_d != S_RUN);
      ready_q    <= (state_d == S_RUN);
    end
  end

  // Next-state and phase-counter logic; soft_rst overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef GTP_USRCLK_SEQ_COUNTERS_EN
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
`endif
    if (soft_rst) begin
      state_d = S_HOLD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          // Count only while the MMCM input clock is valid. Any dropout
          // restarts the full hold time.
          if (!v_s) begin
            cnt_d = '0;
          end else if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT: begin
          if (!v_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else if (l_s) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
`ifdef GTP_USRCLK_SEQ_COUNTERS_EN
            retry_inc = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_SETTLE: begin
          // A lock bounce here is not a failed attempt. Go back and wait
          // for lock again, with a fresh timeout.
          if (!v_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else if (!l_s) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          // A GTP drop and a lock drop in the same cycle count as one loss
          if (!v_s || !l_s) begin
            state_d = S_HOLD;
`ifdef GTP_USRCLK_SEQ_COUNTERS_EN
            loss_inc = 1'b1;
`endif
          end
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef GTP_USRCLK_SEQ_COUNTERS_EN
  // Saturating event counters for lock timeouts and losses in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 8'd0;
      loss_q  <= 8'd0;
    end else begin
      if (retry_inc && (retry_q != 8'hFF)) retry_q <= retry_q + 8'd1;
      if (loss_inc && (loss_q != 8'hFF))   loss_q  <= loss_q + 8'd1;
    end
  end

  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
`else
  assign retry_cnt = 8'd0;
  assign loss_cnt  = 8'd0;
`endif

  assign mmcm_rst = mmcm_rst_q;
  assign usr_rst  = usr_rst_q;
  assign ready    = ready_q;
  assign state    = state_q;

endmodule

// File: tb/tb_gtp_usrclk_seq.sv
// Directed bench for gtp_usrclk_seq. The bring-up sequence is driven from a
// per-cycle vector table. Loss, soft reset, SETTLE bounce, timeout,
// saturation and async reset each use a hand-written sequence.
// Inputs change 1 ns after the rising edge. Outputs are sampled at that
// same point.

module tb_gtp_usrclk_seq;

`ifdef GTP_USRCLK_SEQ_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic       gtp_clk_valid, pll_lock, soft_rst;
  logic       mmcm_rst, usr_rst, ready;
  logic [1:0] state;
  logic [7:0] retry_cnt, loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  gtp_usrclk_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(10),
    .CNT_W        (17)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gtp_clk_valid(gtp_clk_valid),
    .pll_lock     (pll_lock),
    .soft_rst     (soft_rst),
    .mmcm_rst     (mmcm_rst),
    .usr_rst      (usr_rst),
    .ready        (ready),
    .state        (state),
    .retry_cnt    (retry_cnt),
    .loss_cnt     (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       l;
    logic [1:0] st;
    logic       mm;
    logic       usr;
    logic       rdy;
  } vec_t;

  vec_t tbl [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string name, input logic [1:0] st);
    chk({name, ".state"}, 32'(state), 32'(st));
    chk({name, ".mmcm_rst"}, 32'(mmcm_rst), 32'(st == 2'd0));
    chk({name, ".usr_rst"}, 32'(usr_rst), 32'(st != 2'd3));
    chk({name, ".ready"}, 32'(ready), 32'(st == 2'd3));
  endtask

  // Advance until state reaches tgt; an exhausted budget is a failure
  task automatic wait_state(input logic [1:0] tgt, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (state == tgt) break;
    end
    chk({name, ".reach"}, 32'(state), 32'(tgt));
  endtask

  initial begin
    logic [1:0] st_exp [18];
    rst_n         = 1'b0;
    gtp_clk_valid = 1'b1;
    pll_lock      = 1'b1;
    soft_rst      = 1'b0;

    // Expected state after each edge following reset release. v_s rises
    // after edge 2. HOLD counts 4 cycles, WAIT takes 1 cycle and SETTLE 10,
    // so ready appears after edge 17 (15 cycles after v_s).
    st_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2,
               2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 18; k++) begin
      tbl[k].v   = 1'b1;
      tbl[k].l   = 1'b1;
      tbl[k].st  = st_exp[k];
      tbl[k].mm  = (st_exp[k] == 2'd0);
      tbl[k].usr = (st_exp[k] != 2'd3);
      tbl[k].rdy = (st_exp[k] == 2'd3);
    end

    // Reset state
    repeat (3) tick();
    chk_outs("reset", 2'd0);
    chk("reset.retry", 32'(retry_cnt), 0);
    chk("reset.loss", 32'(loss_cnt), 0);

    // Bring-up, table driven
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      gtp_clk_valid = tbl[k].v;
      pll_lock      = tbl[k].l;
      tick();
      chk($sformatf("bringup[%0d].state", k), 32'(state), 32'(tbl[k].st));
      chk($sformatf("bringup[%0d].mmcm", k), 32'(mmcm_rst), 32'(tbl[k].mm));
      chk($sformatf("bringup[%0d].usr", k), 32'(usr_rst), 32'(tbl[k].usr));
      chk($sformatf("bringup[%0d].ready", k), 32'(ready), 32'(tbl[k].rdy));
    end

    // Lock loss in RUN: 2 cycles of sync, then HOLD on the third edge
    pll_lock = 1'b0;
    tick(); tick();
    chk("lossl.still_run", 32'(state), 3);
    tick();
    chk_outs("lossl", 2'd0);
    chk("lossl.cnt", 32'(loss_cnt), CNT_EN ? 1 : 0);
    pll_lock = 1'b1;
    wait_state(2'd3, 60, "relock1");

    // GTP valid and lock dropping together count as a single loss
    gtp_clk_valid = 1'b0;
    pll_lock      = 1'b0;
    tick(); tick(); tick();
    chk_outs("lossboth", 2'd0);
    tick(); tick();
    chk("lossboth.cnt", 32'(loss_cnt), CNT_EN ? 2 : 0);
    gtp_clk_valid = 1'b1;
    pll_lock      = 1'b1;
    wait_state(2'd3, 60, "relock2");

    // soft_rst in RUN with lock good: HOLD on the next edge, no loss counted
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk_outs("softrst", 2'd0);
    chk("softrst.loss", 32'(loss_cnt), CNT_EN ? 2 : 0);

    // Lock bounce in SETTLE: l_s is low only for the decision at count 7
    wait_state(2'd2, 30, "settle_in");      // S0: SETTLE entered, count 0
    repeat (5) tick();                      // S0+5
    pll_lock = 1'b0;
    tick();                                 // S0+6
    pll_lock = 1'b1;
    tick();                                 // S0+7, count 7
    chk("bounce.pre", 32'(state), 2);
    tick();                                 // S0+8
    chk_outs("bounce.wait", 2'd1);
    chk("bounce.retry", 32'(retry_cnt), 0);
    tick();                                 // S0+9
    chk("bounce.resettle", 32'(state), 2);
    repeat (9) tick();                      // S0+18
    chk("bounce.not_yet", 32'(state), 2);
    tick();                                 // S0+19
    chk_outs("bounce.run", 2'd3);

    // Lock timeout: exact HOLD and WAIT_LOCK durations, then retry count
    pll_lock = 1'b0;
    tick(); tick(); tick();                 // H0
    chk("tmo.hold", 32'(state), 0);
    chk("tmo.loss", 32'(loss_cnt), CNT_EN ? 3 : 0);
    repeat (3) tick();
    chk("tmo.hold_end", 32'(state), 0);
    tick();                                 // W0
    chk("tmo.wait_in", 32'(state), 1);
    repeat (99) tick();
    chk_outs("tmo.wait_end", 2'd1);
    tick();
    chk_outs("tmo.back_hold", 2'd0);
    chk("tmo.retry1", 32'(retry_cnt), CNT_EN ? 1 : 0);

    // 299 further timeouts, 300 in total: the counter saturates at 255
    for (int r = 0; r < 299; r++) begin
      wait_state(2'd1, 20, "sat.wait");
      wait_state(2'd0, 120, "sat.hold");
    end
    chk("sat.retry", 32'(retry_cnt), CNT_EN ? 255 : 0);
    chk("sat.loss", 32'(loss_cnt), CNT_EN ? 3 : 0);

    // Async reset mid-SETTLE takes effect without a clock edge
    pll_lock = 1'b1;
    wait_state(2'd2, 30, "arst.settle");
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("arst", 2'd0);
    chk("arst.retry", 32'(retry_cnt), 0);
    chk("arst.loss", 32'(loss_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
